// File: rtl/wbxbc_chk_pkg.sv
// Shared definitions for the Wishbone initiator-side protocol checker:
// violation bit indices, checker state encoding and a lowest-set-bit helper.
package wbxbc_chk_pkg;

  localparam int VIOL_WIDTH       = 8;

  localparam int VIOL_MULTI_TERM  = 0;
  localparam int VIOL_ORPHAN_TERM = 1;
  localparam int VIOL_OVERFLOW    = 2;
  localparam int VIOL_CYC_DROP    = 3;
  localparam int VIOL_STALL_TO    = 4;
  localparam int VIOL_ACK_TO      = 5;
  localparam int VIOL_STB_NO_CYC  = 6;
  localparam int VIOL_UNSTABLE    = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } chk_state_e;

  function automatic logic [2:0] lsb_idx(input logic [VIOL_WIDTH-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = VIOL_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wbxbc_chk_tmr.sv
// Saturating run-length timer: counts consecutive cycles with run_i high and
// flags the sample on which the run length reaches THRESH (and any beyond it).
module wbxbc_chk_tmr #(
  parameter int THRESH = 64
) (
  input  logic clk_i,
  input  logic sync_rst_i,
  input  logic run_i,
  output logic hit_o
);

  localparam int CW = $clog2(THRESH + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = (cnt_q == CW'(THRESH)) ? cnt_q : cnt_q + 1'b1;
  end

  // Current sample is run number cnt_q+1, so THRESH-1 completed runs means this one hits.
  assign hit_o = run_i & (cnt_q >= CW'(THRESH - 1));

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_itr_chk.sv
// Passive pipelined Wishbone initiator-port checker with sticky violation flags.
// Optional capture of the first violation is enabled by WBXBC_CHK_CAPTURE_EN.
module wb_itr_chk
  import wbxbc_chk_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_OUTSTD = 4,
  parameter int STALL_TMO  = 64,
  parameter int ACK_TMO    = 256
) (
  input  logic                            clk_i,
  input  logic                            sync_rst_i,
  input  logic                            itr_cyc_i,
  input  logic                            itr_stb_i,
  input  logic                            itr_we_i,
  input  logic                            itr_lock_i,
  input  logic [SEL_WIDTH-1:0]            itr_sel_i,
  input  logic [ADR_WIDTH-1:0]            itr_adr_i,
  input  logic [DAT_WIDTH-1:0]            itr_dat_i,
  input  logic                            itr_ack_o,
  input  logic                            itr_err_o,
  input  logic                            itr_rty_o,
  input  logic                            itr_stall_o,
  input  logic                            clr_i,
  output logic [VIOL_WIDTH-1:0]           viol_o,
  output logic                            viol_any_o,
  output logic [$clog2(MAX_OUTSTD+1)-1:0] outstd_o
`ifdef WBXBC_CHK_CAPTURE_EN
  ,
  output logic [ADR_WIDTH-1:0]            cap_adr_o,
  output logic                            cap_we_o,
  output logic [2:0]                      cap_code_o
`endif
);

  localparam int OW = $clog2(MAX_OUTSTD + 1);

  logic [OW-1:0]         outstd_q, outstd_d;
  chk_state_e            state_q, state_d;
  logic [VIOL_WIDTH-1:0] viol_q, viol_d, viol_set;

  // Previous-cycle stalled request, used for the stability check.
  logic                  stl_q, stl_d;
  logic [ADR_WIDTH-1:0]  padr_q, padr_d;
  logic                  pwe_q, pwe_d;
  logic [SEL_WIDTH-1:0]  psel_q, psel_d;
  logic [DAT_WIDTH-1:0]  pdat_q, pdat_d;

  logic req, term_raw, term, multi, busy, in_abort, at_max, drop, stalled;
  logic stall_hit, ack_hit;
  logic unused_lock;

  assign unused_lock = itr_lock_i;

  assign stalled  = itr_cyc_i & itr_stb_i & itr_stall_o;
  assign req      = itr_cyc_i & itr_stb_i & ~itr_stall_o;
  assign term_raw = itr_ack_o | itr_err_o | itr_rty_o;
  assign multi    = (itr_ack_o & itr_err_o) | (itr_ack_o & itr_rty_o) | (itr_err_o & itr_rty_o);
  assign busy     = (outstd_q != '0);
  assign in_abort = (state_q == ABORT);
  assign term     = term_raw & busy & ~in_abort;
  assign at_max   = (outstd_q == OW'(MAX_OUTSTD));
  assign drop     = (state_q == ACTIVE) & ~itr_cyc_i & busy;

  wbxbc_chk_tmr #(.THRESH(STALL_TMO)) u_stall_tmr (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .run_i      (stalled),
    .hit_o      (stall_hit)
  );

  wbxbc_chk_tmr #(.THRESH(ACK_TMO)) u_ack_tmr (
    .clk_i      (clk_i),
    .sync_rst_i (sync_rst_i),
    .run_i      (busy & ~term_raw),
    .hit_o      (ack_hit)
  );

  always_comb begin
    viol_set                   = '0;
    viol_set[VIOL_MULTI_TERM]  = itr_cyc_i & multi;
    viol_set[VIOL_ORPHAN_TERM] = term_raw & ~busy & ~in_abort;
    viol_set[VIOL_OVERFLOW]    = req & ~term & at_max;
    viol_set[VIOL_CYC_DROP]    = drop;
    viol_set[VIOL_STALL_TO]    = stall_hit;
    viol_set[VIOL_ACK_TO]      = ack_hit;
    viol_set[VIOL_STB_NO_CYC]  = itr_stb_i & ~itr_cyc_i;
    viol_set[VIOL_UNSTABLE]    = stl_q & itr_cyc_i & itr_stb_i &
                                 ((itr_adr_i != padr_q) | (itr_we_i != pwe_q) |
                                  (itr_sel_i != psel_q) | (itr_we_i & (itr_dat_i != pdat_q)));

    // Sets override a same-cycle clear.
    viol_d = (clr_i ? '0 : viol_q) | viol_set;

    outstd_d = outstd_q;
    if (drop)                         outstd_d = '0;
    else if (req & ~term & ~at_max)   outstd_d = outstd_q + 1'b1;
    else if (term & ~req)             outstd_d = outstd_q - 1'b1;

    state_d = state_q;
    case (state_q)
      IDLE:    if (itr_cyc_i) state_d = ACTIVE;
      ACTIVE:  if (!itr_cyc_i) state_d = busy ? ABORT : IDLE;
      ABORT:   state_d = itr_cyc_i ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase

    stl_d  = stalled;
    padr_d = itr_adr_i;
    pwe_d  = itr_we_i;
    psel_d = itr_sel_i;
    pdat_d = itr_dat_i;
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state_q  <= IDLE;
      outstd_q <= '0;
      viol_q   <= '0;
      stl_q    <= 1'b0;
      padr_q   <= '0;
      pwe_q    <= 1'b0;
      psel_q   <= '0;
      pdat_q   <= '0;
    end else begin
      state_q  <= state_d;
      outstd_q <= outstd_d;
      viol_q   <= viol_d;
      stl_q    <= stl_d;
      padr_q   <= padr_d;
      pwe_q    <= pwe_d;
      psel_q   <= psel_d;
      pdat_q   <= pdat_d;
    end
  end

  assign viol_o     = viol_q;
  assign viol_any_o = |viol_q;
  assign outstd_o   = outstd_q;

`ifdef WBXBC_CHK_CAPTURE_EN
  logic [ADR_WIDTH-1:0] cap_adr_q, cap_adr_d;
  logic                 cap_we_q, cap_we_d;
  logic [2:0]           cap_code_q, cap_code_d;

  // Load on the first violation since reset/clear; a bare clear empties the capture.
  always_comb begin
    cap_adr_d  = cap_adr_q;
    cap_we_d   = cap_we_q;
    cap_code_d = cap_code_q;
    if ((|viol_set) && ((viol_q == '0) || clr_i)) begin
      cap_adr_d  = itr_adr_i;
      cap_we_d   = itr_we_i;
      cap_code_d = lsb_idx(viol_set);
    end else if (clr_i) begin
      cap_adr_d  = '0;
      cap_we_d   = 1'b0;
      cap_code_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      cap_adr_q  <= '0;
      cap_we_q   <= 1'b0;
      cap_code_q <= '0;
    end else begin
      cap_adr_q  <= cap_adr_d;
      cap_we_q   <= cap_we_d;
      cap_code_q <= cap_code_d;
    end
  end

  assign cap_adr_o  = cap_adr_q;
  assign cap_we_o   = cap_we_q;
  assign cap_code_o = cap_code_q;
`endif

endmodule

// File: tb/tb_wb_itr_chk.sv
// Self-checking bench for wb_itr_chk: directed scenarios plus randomized bus
// traffic against a cycle-level behavioural model of the checker rules.
module tb_wb_itr_chk;

  localparam int AW = 16, DW = 16, SW = 2;
  localparam int MAXO = 4, STMO = 64, ATMO = 256;

  logic          clk = 1'b0;
  logic          rst, cyc, stb, we, lock, ack, err, rty, stall, clr;
  logic [SW-1:0] sel;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat;
  logic [7:0]    viol_o;
  logic          viol_any_o;
  logic [2:0]    outstd_o;
`ifdef WBXBC_CHK_CAPTURE_EN
  logic [AW-1:0] cap_adr_o;
  logic          cap_we_o;
  logic [2:0]    cap_code_o;
`endif

  always #5 clk = ~clk;

  wb_itr_chk #(
    .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW),
    .MAX_OUTSTD(MAXO), .STALL_TMO(STMO), .ACK_TMO(ATMO)
  ) dut (
    .clk_i(clk), .sync_rst_i(rst),
    .itr_cyc_i(cyc), .itr_stb_i(stb), .itr_we_i(we), .itr_lock_i(lock),
    .itr_sel_i(sel), .itr_adr_i(adr), .itr_dat_i(dat),
    .itr_ack_o(ack), .itr_err_o(err), .itr_rty_o(rty), .itr_stall_o(stall),
    .clr_i(clr), .viol_o(viol_o), .viol_any_o(viol_any_o), .outstd_o(outstd_o)
`ifdef WBXBC_CHK_CAPTURE_EN
    , .cap_adr_o(cap_adr_o), .cap_we_o(cap_we_o), .cap_code_o(cap_code_o)
`endif
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: bus-cycle view (in cycle / aborting / idle), open request count,
  // run lengths of stalling and of waiting for a response, and the last stalled request.
  int         m_out, m_srun, m_arun;
  bit         m_incyc, m_abort;
  logic [7:0] m_viol;
  bit         m_pst;
  logic [AW-1:0] m_padr;
  logic [DW-1:0] m_pdat;
  logic          m_pwe;
  logic [SW-1:0] m_psel;
  logic [AW-1:0] m_cadr;
  logic          m_cwe;
  logic [2:0]    m_ccode;

  task automatic model_step();
    int nterm;
    bit req, tc, drop;
    logic [7:0] s;
    if (rst) begin
      m_out = 0; m_srun = 0; m_arun = 0; m_incyc = 0; m_abort = 0; m_viol = 0; m_pst = 0;
      m_padr = 0; m_pdat = 0; m_pwe = 0; m_psel = 0; m_cadr = 0; m_cwe = 0; m_ccode = 0;
      return;
    end
    nterm = int'(ack) + int'(err) + int'(rty);
    req   = cyc && stb && !stall;
    tc    = nterm > 0 && m_out > 0 && !m_abort;
    drop  = m_incyc && !m_abort && !cyc && m_out > 0;
    s = 0;
    if (cyc && nterm > 1)                    s[0] = 1;
    if (nterm > 0 && m_out == 0 && !m_abort) s[1] = 1;
    if (req && !tc && m_out == MAXO)         s[2] = 1;
    if (drop)                                s[3] = 1;
    if (cyc && stb && stall) m_srun = (m_srun < STMO) ? m_srun + 1 : STMO; else m_srun = 0;
    if (m_srun >= STMO) s[4] = 1;
    if (m_out > 0 && nterm == 0) m_arun = (m_arun < ATMO) ? m_arun + 1 : ATMO; else m_arun = 0;
    if (m_arun >= ATMO) s[5] = 1;
    if (stb && !cyc) s[6] = 1;
    if (m_pst && cyc && stb &&
        (adr != m_padr || we != m_pwe || sel != m_psel || (we && dat != m_pdat))) s[7] = 1;
    m_pst = cyc && stb && stall;
    m_padr = adr; m_pdat = dat; m_pwe = we; m_psel = sel;
    if (s != 0 && (m_viol == 0 || clr)) begin
      m_cadr = adr; m_cwe = we;
      for (int b = 0; b < 8; b++) if (s[b]) begin m_ccode = 3'(b); break; end
    end else if (clr) begin
      m_cadr = 0; m_cwe = 0; m_ccode = 0;
    end
    m_viol = (clr ? 8'h00 : m_viol) | s;
    if (drop) m_out = 0;
    else begin
      m_out = m_out + (req ? 1 : 0) - (tc ? 1 : 0);
      if (m_out > MAXO) m_out = MAXO;
      if (m_out < 0) m_out = 0;
    end
    // A dropped cycle with open requests spends one cycle aborting.
    m_abort = drop;
    m_incyc = drop ? 1'b1 : cyc;
    if (!drop && m_incyc == 0) m_abort = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("viol", viol_o, m_viol);
    chk("viol_any", viol_any_o, (m_viol != 0));
    chk("outstd", outstd_o, m_out);
`ifdef WBXBC_CHK_CAPTURE_EN
    chk("cap_adr", cap_adr_o, m_cadr);
    chk("cap_we", cap_we_o, m_cwe);
    chk("cap_code", cap_code_o, m_ccode);
`endif
  endtask

  task automatic bus(input logic c, input logic s, input logic st,
                     input logic a, input logic e, input logic r);
    cyc = c; stb = s; stall = st; ack = a; err = e; rty = r; rst = 0; clr = 0;
  endtask

  task automatic do_reset();
    bus(0, 0, 0, 0, 0, 0); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    we = 0; lock = 0; sel = 2'b11; adr = 16'h1234; dat = 16'hA5A5;
    bus(0, 0, 0, 0, 0, 0);
    do_reset();
    chk("rst_viol", viol_o, 0); chk("rst_outstd", outstd_o, 0);

    // Pipelined reads with delayed acks.
    bus(1, 1, 0, 0, 0, 0); tick(); chk("t1_o1", outstd_o, 1);
    bus(1, 1, 0, 0, 0, 0); tick(); chk("t1_o2", outstd_o, 2);
    bus(1, 0, 0, 1, 0, 0); tick(); chk("t1_o3", outstd_o, 1);
    bus(1, 0, 0, 1, 0, 0); tick(); chk("t1_o4", outstd_o, 0);
    bus(0, 0, 0, 0, 0, 0); tick(); chk("t1_viol", viol_o, 0);

    // Overflow on the fifth unacknowledged request.
    do_reset();
    for (int i = 0; i < 4; i++) begin bus(1, 1, 0, 0, 0, 0); tick(); end
    chk("t2_pre", viol_o[2], 0);
    bus(1, 1, 0, 0, 0, 0); tick();
    chk("t2_ovf", viol_o[2], 1); chk("t2_sat", outstd_o, 4);

    // Double termination, then clear.
    do_reset();
    bus(1, 1, 0, 0, 0, 0); tick();
    bus(1, 0, 0, 1, 1, 0); tick(); chk("t3_multi", viol_o, 8'h01);
    bus(1, 0, 0, 0, 0, 0); clr = 1; tick(); chk("t3_clr", viol_o, 0);

    // Stall timeout, then address change while stalled.
    do_reset();
    for (int i = 0; i < 63; i++) begin bus(1, 1, 1, 0, 0, 0); tick(); end
    chk("t4_pre", viol_o[4], 0);
    bus(1, 1, 1, 0, 0, 0); tick(); chk("t4_sto", viol_o[4], 1);
    chk("t4_stable", viol_o[7], 0);
    adr = 16'h5678; tick(); chk("t4_unst", viol_o[7], 1);
    adr = 16'h1234;

    // Cycle dropped with two open requests; ack while aborting is ignored.
    do_reset();
    bus(1, 1, 0, 0, 0, 0); tick(); bus(1, 1, 0, 0, 0, 0); tick();
    bus(0, 0, 0, 0, 0, 0); tick(); chk("t5_drop", viol_o[3], 1); chk("t5_out", outstd_o, 0);
    bus(0, 0, 0, 1, 0, 0); tick(); chk("t5_orph", viol_o[1], 0);
    bus(0, 0, 0, 0, 0, 0); tick();

    // Reset in mid-transaction with flags set.
    do_reset();
    bus(1, 1, 0, 0, 0, 0); tick();
    bus(1, 1, 0, 1, 1, 0); tick();
    bus(1, 1, 0, 0, 0, 0); tick(); bus(1, 1, 0, 0, 0, 0); tick();
    chk("t6_out3", outstd_o, 3); chk("t6_flag", viol_o, 8'h01);
    bus(1, 0, 0, 0, 0, 0); rst = 1; tick(); rst = 0;
    chk("t6_viol", viol_o, 0); chk("t6_any", viol_any_o, 0); chk("t6_out", outstd_o, 0);

    // Acknowledge timeout.
    do_reset();
    bus(1, 1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 255; i++) begin bus(1, 0, 0, 0, 0, 0); tick(); end
    chk("t7_pre", viol_o[5], 0);
    bus(1, 0, 0, 0, 0, 0); tick(); chk("t7_ato", viol_o[5], 1);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bus($urandom_range(0, 99) < 88, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 3) stb = 1;
      we   = $urandom_range(0, 99) < 10 ? ~we : we;
      adr  = $urandom_range(0, 99) < 10 ? 16'($urandom_range(0, 3)) : adr;
      sel  = $urandom_range(0, 99) < 5 ? 2'($urandom_range(0, 3)) : sel;
      dat  = $urandom_range(0, 99) < 10 ? 16'($urandom_range(0, 3)) : dat;
      lock = 1'($urandom_range(0, 1));
      clr  = $urandom_range(0, 99) < 4;
      rst  = $urandom_range(0, 999) < 8;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
